// File: rtl/pong_pkg.sv
// pong_pkg: playfield geometry, derived limits and FSM
// encoding shared by the Pong frame sequencer.
package pong_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BALL_SIZE    = 8;
  localparam int PAD_W        = 8;
  localparam int PAD_H        = 64;
  localparam int PAD_L_X      = 16;
  localparam int PAD_R_X      = 616;
  localparam int BALL_SPEED   = 2;
  localparam int PAD_SPEED    = 4;
  localparam int SERVE_FRAMES = 60;
  localparam int SCORE_MAX    = 9;

  localparam int PAD_Y_MAX  = V_ACTIVE - PAD_H;
  localparam int BALL_Y_MAX = V_ACTIVE - BALL_SIZE;
  localparam int BALL_X_MAX = H_ACTIVE - BALL_SIZE;
  localparam int BALL_X_CTR = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int BALL_Y_CTR = (V_ACTIVE - BALL_SIZE) / 2;
  localparam int PAD_Y_CTR  = (V_ACTIVE - PAD_H) / 2;
  localparam int HIT_L_X    = PAD_L_X + PAD_W;
  localparam int HIT_R_X    = PAD_R_X - BALL_SIZE;

  localparam int SERVE_W = 6;

  typedef logic [9:0]         coord_t;
  typedef logic signed [10:0] scoord_t;
  typedef logic [3:0]         score_t;
  typedef logic [SERVE_W-1:0] serve_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PADDLE,
    ST_BALL_Y,
    ST_BALL_X,
    ST_DONE
  } state_t;

  function automatic scoord_t widen(input coord_t v);
    return scoord_t'({1'b0, v});
  endfunction

  function automatic scoord_t sc(input int v);
    return scoord_t'(v);
  endfunction

  function automatic coord_t cc(input int v);
    return coord_t'(v);
  endfunction

  function automatic score_t sat_inc(input score_t s);
    score_t r;
    r = s + score_t'(1);
    if (s >= score_t'(SCORE_MAX))
      r = score_t'(SCORE_MAX);
    return r;
  endfunction

endpackage

// File: rtl/pong_frame_ctrl_paddle_step.sv
// pong_paddle_step: one paddle's per-frame move,
// stepped by PAD_SPEED and clamped to the playfield.
module pong_paddle_step
  import pong_pkg::*;
(
  input  logic [9:0] y,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y_next
);

  scoord_t y_up;
  scoord_t y_dn;

  assign y_up = widen(y) - sc(PAD_SPEED);
  assign y_dn = widen(y) + sc(PAD_SPEED);

  // Move toward a single pressed button; both or none holds.
  always_comb begin
    y_next = y;
    unique case (1'b1)
      up && !dn:
        y_next = (y_up < sc(0)) ? '0 : y_up[9:0];
      dn && !up:
        y_next = (y_dn > sc(PAD_Y_MAX)) ?
                 cc(PAD_Y_MAX) : y_dn[9:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/pong_frame_ctrl.sv
// pong_frame_ctrl: once-per-frame game update sequenced
// from the vsync falling edge on the pixel clock.
module pong_frame_ctrl
  import pong_pkg::*;
(
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       update_done
);

  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic       vsync_q;
  logic       tick;

  state_t     state_q;
  state_t     state_d;

  logic       dir_x_rt;
  logic       dir_y_dn;
  serve_t     serve_cnt;
  logic       serving;

  logic [9:0] pl_next;
  logic [9:0] pr_next;

  scoord_t    ny;
  logic [9:0] by_next;
  logic       dy_next;

  scoord_t    nx;
  logic       ov_l;
  logic       ov_r;
  logic       hit_l;
  logic       hit_r;
  logic       miss_l;
  logic       miss_r;

  // Button synchronizers and vsync edge register.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      vsync_q  <= 1'b0;
    end else begin
      btn_meta <= {btn_l_up, btn_l_dn,
                   btn_r_up, btn_r_dn};
      btn_sync <= btn_meta;
      vsync_q  <= vsync;
    end
  end

  assign tick    = vsync_q & ~vsync;
  assign serving = (serve_cnt != '0);

  // Sequencer state register.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Sequencer next state; ticks are only taken in IDLE.
  always_comb begin
    state_d     = state_q;
    update_done = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (tick) state_d = ST_PADDLE;
      ST_PADDLE: state_d = ST_BALL_Y;
      ST_BALL_Y: state_d = ST_BALL_X;
      ST_BALL_X: state_d = ST_DONE;
      ST_DONE: begin
        update_done = 1'b1;
        state_d     = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  pong_paddle_step u_pad_l (
    .y      (pad_l_y),
    .up     (btn_sync[3]),
    .dn     (btn_sync[2]),
    .y_next (pl_next)
  );

  pong_paddle_step u_pad_r (
    .y      (pad_r_y),
    .up     (btn_sync[1]),
    .dn     (btn_sync[0]),
    .y_next (pr_next)
  );

  // Vertical step with bounce off top and bottom walls.
  always_comb begin
    ny = dir_y_dn ?
         widen(ball_y) + sc(BALL_SPEED) :
         widen(ball_y) - sc(BALL_SPEED);
    by_next = ny[9:0];
    dy_next = dir_y_dn;
    unique case (1'b1)
      ny < sc(0): begin
        by_next = '0;
        dy_next = 1'b1;
      end
      ny > sc(BALL_Y_MAX): begin
        by_next = cc(BALL_Y_MAX);
        dy_next = 1'b0;
      end
      default: ;
    endcase
  end

  // Horizontal step; paddle hits win over misses.
  always_comb begin
    nx = dir_x_rt ?
         widen(ball_x) + sc(BALL_SPEED) :
         widen(ball_x) - sc(BALL_SPEED);
    ov_l = (widen(ball_y) + sc(BALL_SIZE) >
            widen(pad_l_y)) &&
           (widen(ball_y) <
            widen(pad_l_y) + sc(PAD_H));
    ov_r = (widen(ball_y) + sc(BALL_SIZE) >
            widen(pad_r_y)) &&
           (widen(ball_y) <
            widen(pad_r_y) + sc(PAD_H));
    hit_l  = !dir_x_rt && ov_l &&
             (nx <= sc(HIT_L_X));
    hit_r  = dir_x_rt && ov_r &&
             (nx + sc(BALL_SIZE) >= sc(PAD_R_X));
    miss_l = !dir_x_rt && !hit_l &&
             (nx < sc(0));
    miss_r = dir_x_rt && !hit_r &&
             (nx > sc(BALL_X_MAX));
  end

  // Game state registers, written one phase per cycle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x    <= cc(BALL_X_CTR);
      ball_y    <= cc(BALL_Y_CTR);
      pad_l_y   <= cc(PAD_Y_CTR);
      pad_r_y   <= cc(PAD_Y_CTR);
      score_l   <= '0;
      score_r   <= '0;
      dir_x_rt  <= 1'b1;
      dir_y_dn  <= 1'b1;
      serve_cnt <= serve_t'(SERVE_FRAMES);
    end else begin
      if (state_q == ST_PADDLE) begin
        pad_l_y <= pl_next;
        pad_r_y <= pr_next;
      end
      if (state_q == ST_BALL_Y && !serving) begin
        ball_y   <= by_next;
        dir_y_dn <= dy_next;
      end
      if (state_q == ST_BALL_X) begin
        if (serving) begin
          serve_cnt <= serve_cnt - serve_t'(1);
        end else begin
          unique case (1'b1)
            hit_l: begin
              ball_x   <= cc(HIT_L_X);
              dir_x_rt <= 1'b1;
            end
            hit_r: begin
              ball_x   <= cc(HIT_R_X);
              dir_x_rt <= 1'b0;
            end
            miss_l: begin
              score_r   <= sat_inc(score_r);
              ball_x    <= cc(BALL_X_CTR);
              ball_y    <= cc(BALL_Y_CTR);
              serve_cnt <= serve_t'(SERVE_FRAMES);
              dir_x_rt  <= 1'b0;
            end
            miss_r: begin
              score_l   <= sat_inc(score_l);
              ball_x    <= cc(BALL_X_CTR);
              ball_y    <= cc(BALL_Y_CTR);
              serve_cnt <= serve_t'(SERVE_FRAMES);
              dir_x_rt  <= 1'b1;
            end
            default: ball_x <= nx[9:0];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// tb_pong_frame_ctrl: directed frames, expected state
// queued per frame and checked on each update_done.
module tb_pong_frame_ctrl;

  logic       pixel_clk;
  logic       rst_n;
  logic       vsync;
  logic       btn_l_up, btn_l_dn;
  logic       btn_r_up, btn_r_dn;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic       update_done;

  pong_frame_ctrl dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .btn_l_up    (btn_l_up),
    .btn_l_dn    (btn_l_dn),
    .btn_r_up    (btn_r_up),
    .btn_r_dn    (btn_r_dn),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .pad_l_y     (pad_l_y),
    .pad_r_y     (pad_r_y),
    .score_l     (score_l),
    .score_r     (score_r),
    .update_done (update_done)
  );

  typedef struct {
    int bx, by, pl, pr, sl, sr, at;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   ncyc    = 0;

  int mbx, mby, mpl, mpr, msl, msr;
  int mdx, mdy, mserve;

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  function automatic void check(
    input string nm, input int act, input int want);
    vectors++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: dut=%0d want=%0d",
               nm, act, want);
    end
  endfunction

  function automatic int pstep(
    input int y, input bit u, input bit d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic void model_reset();
    mbx = 316; mby = 236; mpl = 208; mpr = 208;
    msl = 0; msr = 0; mdx = 1; mdy = 1;
    mserve = 60;
  endfunction

  function automatic void model_step(
    input bit lu, input bit ld,
    input bit ru, input bit rd);
    int nx, ny;
    bit ol, orr;
    mpl = pstep(mpl, lu, ld);
    mpr = pstep(mpr, ru, rd);
    if (mserve > 0) begin
      mserve--;
      return;
    end
    ny = mby + 2 * mdy;
    if (ny < 0) begin mby = 0; mdy = 1; end
    else if (ny > 472) begin mby = 472; mdy = -1; end
    else mby = ny;
    nx  = mbx + 2 * mdx;
    ol  = (mby + 8 > mpl) && (mby < mpl + 64);
    orr = (mby + 8 > mpr) && (mby < mpr + 64);
    if (mdx < 0 && nx <= 24 && ol) begin
      mbx = 24; mdx = 1;
    end else if (mdx > 0 && nx + 8 >= 616 && orr) begin
      mbx = 608; mdx = -1;
    end else if (nx < 0) begin
      msr = (msr >= 9) ? 9 : msr + 1;
      mbx = 316; mby = 236; mserve = 60; mdx = -1;
    end else if (nx > 632) begin
      msl = (msl >= 9) ? 9 : msl + 1;
      mbx = 316; mby = 236; mserve = 60; mdx = 1;
    end else begin
      mbx = nx;
    end
  endfunction

  // Scoreboard: pop and compare on every update_done.
  always @(negedge pixel_clk) begin
    exp_t e;
    ncyc++;
    if (rst_n && update_done) begin
      check("done_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("done_latency", ncyc, e.at);
        check("ball_x", ball_x, e.bx);
        check("ball_y", ball_y, e.by);
        check("pad_l_y", pad_l_y, e.pl);
        check("pad_r_y", pad_r_y, e.pr);
        check("score_l", score_l, e.sl);
        check("score_r", score_r, e.sr);
      end
    end
  end

  task automatic frame(
    input bit lu, input bit ld,
    input bit ru, input bit rd);
    exp_t e;
    btn_l_up = lu; btn_l_dn = ld;
    btn_r_up = ru; btn_r_dn = rd;
    repeat (4) @(posedge pixel_clk);
    #1;
    model_step(lu, ld, ru, rd);
    e.bx = mbx; e.by = mby; e.pl = mpl; e.pr = mpr;
    e.sl = msl; e.sr = msr; e.at = ncyc + 5;
    q.push_back(e);
    vsync = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    vsync = 1'b1;
    repeat (5) @(posedge pixel_clk);
    #1;
    check("done_seen", q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset();
    check("rst_ball_x", ball_x, 316);
    check("rst_ball_y", ball_y, 236);
    check("rst_pad_l", pad_l_y, 208);
    check("rst_pad_r", pad_r_y, 208);
    check("rst_score_l", score_l, 0);
    check("rst_score_r", score_r, 0);
    check("rst_done", update_done, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vsync = 1'b1;
    btn_l_up = 0; btn_l_dn = 0;
    btn_r_up = 0; btn_r_dn = 0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: dut=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    do_reset();

    // Idle frames: ball held for serve, paddles centred.
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0);
    check("idle_ball_x", ball_x, 316);
    check("idle_ball_y", ball_y, 236);

    // Both buttons hold, then up clamps at the top.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      frame(1, 1, 0, 0);
      check("pad_both", pad_l_y, 208);
    end
    for (int i = 1; i <= 60; i++) begin
      frame(1, 0, 0, 0);
      check("pad_up", pad_l_y,
            (208 - 4 * i < 0) ? 0 : 208 - 4 * i);
    end

    // Reset landing in BALL_Y: immediate, no done.
    do_reset();
    for (int i = 0; i < 5; i++) frame(1, 0, 0, 0);
    check("pre_rst_pad_l", pad_l_y, 188);
    btn_l_up = 0;
    vsync = 1'b0;
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset();
    vsync = 1'b1;
    repeat (2) @(posedge pixel_clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(posedge pixel_clk);
    #1;
    frame(0, 0, 0, 0);
    check("post_rst_pad_l", pad_l_y, 208);

    // Rally: right hit, left hit, right hit, left miss.
    do_reset();
    n = 0;
    while (mdx == 1 && n < 300) begin
      frame(0, 0, 0, 1);
      n++;
    end
    check("rhit1_x", ball_x, 608);
    check("rhit1_y", ball_y, 418);
    check("rhit1_pad_r", pad_r_y, 416);

    n = 0;
    while (mdx == -1 && n < 400) begin
      frame(n < 13, 0, 0, 0);
      n++;
    end
    check("lhit_x", ball_x, 24);
    check("lhit_y", ball_y, 164);
    check("lhit_pad_l", pad_l_y, 156);
    check("lhit_score_r", score_r, 0);
    check("lhit_score_l", score_l, 0);

    frame(1, 0, 1, 0);
    check("after_lhit_x", ball_x, 26);
    check("after_lhit_y", ball_y, 166);
    n = 1;
    while (mdx == 1 && n < 400) begin
      frame(n < 40, 0, n < 53, 0);
      n++;
    end
    check("rhit2_x", ball_x, 608);
    check("rhit2_y", ball_y, 198);
    check("rhit2_pad_r", pad_r_y, 204);
    check("rhit2_pad_l", pad_l_y, 0);

    n = 0;
    while (msr == 0 && n < 400) begin
      frame(0, 0, 0, 0);
      n++;
    end
    check("miss_score_r", score_r, 1);
    check("miss_score_l", score_l, 0);
    check("miss_x", ball_x, 316);
    check("miss_y", ball_y, 236);

    for (int i = 0; i < 60; i++) begin
      frame(0, 0, 0, 0);
      check("serve_hold_x", ball_x, 316);
    end
    frame(0, 0, 0, 0);
    check("serve_go_x", ball_x, 314);
    check("serve_go_y", ball_y, 238);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/pong_frame_ctrl.md
Name: pong_frame_ctrl

Overview:
Per-frame game-state sequencer for the Pong display path. Once per frame, at the falling edge of vertical sync, it advances both paddles from button inputs, then moves the ball with wall/paddle bounce, miss detection, scoring and serve delay. Its registered coordinates drive the x/y origin inputs of the sprite renderers in the VGA top level, and all of it runs on the pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BALL_SIZE, 8, ball width and height in pixels
PAD_W, 8, paddle width
PAD_H, 64, paddle height
PAD_L_X, 16, left paddle fixed x
PAD_R_X, 616, right paddle fixed x
BALL_SPEED, 2, ball step per frame on each axis
PAD_SPEED, 4, paddle step per frame
SERVE_FRAMES, 60, frames the ball is held after reset or a miss
SCORE_MAX, 9, score saturation value

Ports:
pixel_clk  in  1  pixel clock, the only clock
rst_n  in  1  asynchronous active-low reset
vsync  in  1  active-low vertical sync from the sync generator, same clock domain
btn_l_up  in  1  left paddle up, raw asynchronous button, active-high
btn_l_dn  in  1  left paddle down
btn_r_up  in  1  right paddle up
btn_r_dn  in  1  right paddle down
ball_x  out  10  ball top-left x
ball_y  out  10  ball top-left y
pad_l_y  out  10  left paddle top y
pad_r_y  out  10  right paddle top y
score_l  out  4  left player score
score_r  out  4  right player score
update_done  out  1  one-cycle pulse when the frame update is complete

Behaviour:
- Clocking and reset: one clock (pixel_clk). Reset is asynchronous and active-low on rst_n.
- Reset values (asserted immediately, including mid-sequence):
  - ball_x = (H_ACTIVE-BALL_SIZE)/2 = 316; ball_y = (V_ACTIVE-BALL_SIZE)/2 = 236.
  - pad_l_y = pad_r_y = (V_ACTIVE-PAD_H)/2 = 208.
  - scores 0, update_done 0.
  - dir_x = right, dir_y = down; serve_cnt = SERVE_FRAMES; FSM in IDLE.
- Inputs:
  - Each button passes through a 2-FF synchronizer.
  - vsync is registered once. tick = previous value 1 and current value 0.
- FSM: IDLE -> PADDLE -> BALL_Y -> BALL_X -> DONE -> IDLE.
  - IDLE leaves only on tick. Ticks outside IDLE are ignored.
  - tick is seen at cycle T: PADDLE at T+1, BALL_Y at T+2, BALL_X at T+3, DONE at T+4.
  - update_done = 1 only in DONE. All outputs are stable from T+4 until the next tick.
- PADDLE (each side, same rule):
  - up only: y = max(0, y-PAD_SPEED).
  - down only: y = min(V_ACTIVE-PAD_H, y+PAD_SPEED).
  - both or neither: hold.
- Arithmetic: use 11-bit signed intermediates for every step. Clamp before writing back to 10 bits; outputs never wrap.
- If serve_cnt != 0: BALL_Y and BALL_X leave the ball unchanged, and serve_cnt decrements in BALL_X.
- BALL_Y: ny = ball_y ± BALL_SPEED.
  - ny < 0: ball_y = 0, dir_y = down.
  - ny > V_ACTIVE-BALL_SIZE: ball_y = 472, dir_y = up.
  - otherwise ball_y = ny.
- BALL_X: nx = ball_x ± BALL_SPEED. Overlap tests use the updated ball_y and the updated paddle y.
  - Overlap with a paddle: ball_y+BALL_SIZE > pad_y and ball_y < pad_y+PAD_H.
  - Left hit: moving left, nx <= PAD_L_X+PAD_W, left overlap true. Set ball_x = 24, dir_x = right.
  - Right hit: moving right, nx+BALL_SIZE >= PAD_R_X, right overlap true. Set ball_x = 608, dir_x = left.
  - Left miss: nx < 0. score_r += 1, saturating at SCORE_MAX.
  - Right miss: nx > H_ACTIVE-BALL_SIZE. score_l += 1, saturating.
  - Any miss: ball returns to centre, serve_cnt = SERVE_FRAMES, dir_x points toward the player who missed, dir_y is unchanged.
  - Otherwise ball_x = nx.
- Priority: a paddle hit is checked before a miss on the same step. Edge-of-paddle contact counts as a miss, since the overlap tests use strict inequality.
- Scores never reset except by rst_n.

Decomposition:
- Shared package pong_pkg:
  - Geometry constants: screen size, ball and paddle sizes, paddle x positions, speeds.
  - FSM state encoding.
  - Derived constants: PAD_Y_MAX = 416, BALL_Y_MAX = 472, centre coordinates.
- One sub-module, pong_paddle_step: combinational clamp-and-step for one paddle, instantiated twice.

Test Plan:
- Reset deasserted, 3 frames with no buttons -> ball held at (316,236), paddles at 208, update_done pulses exactly 4 cycles after each vsync falling edge.
- btn_l_up held 60 frames -> pad_l_y falls 208, 204, … and clamps at 0 from frame 52 on. Both buttons held -> pad_l_y unchanged.
- After serve, ball moving up from ball_y = 1 -> ball_y = 0, dir_y = down; next frame ball_y = 2.
- Ball moving left at x = 26 with pad_l_y = ball_y-10 -> ball_x = 24, dir_x = right, score unchanged.
- Ball moving left at x = 1 with left paddle far away -> score_r = 1, ball at (316,236) held 60 frames, then moves left.
- Reset pulsed during BALL_Y (cycle T+2) -> all outputs take reset values at once, no update_done for that frame, normal operation on the next tick.
